// File: rtl/tick_delay_arbiter.sv
// tick_delay_arbiter: round-robin lender of one prescaled delay timer to NREQ requesters
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   req       - per-requester request level, held until gnt
//   dly       - per-requester delay in ticks, slice i = dly[i*DW +: DW], sampled at grant
//   cancel    - aborts a running delay without a done pulse
//   gnt       - one-hot grant pulse
//   done      - one-hot completion pulse
//   active    - one-hot current owner while the timer is lent out
//   busy      - timer lent out
//   tick      - prescaler wrap pulse while running
module tick_delay_arbiter #(
    parameter int NREQ = 3,
    parameter int DIV  = 50000,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] dly,
    input  logic              cancel,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   active,
    output logic              busy,
    output logic              tick
);
    localparam int IW = $clog2(NREQ);
    // ZERO is the extra DONE-bound cycle taken by a zero-length delay so that
    // its done pulse lands one cycle after the grant.
    typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;
    state_t          state, state_n;
    logic [DW-1:0]   cnt, cnt_n;
    logic [31:0]     pre, pre_n;
    logic [IW-1:0]   own, own_n, last, last_n, idx, win;
    logic [NREQ-1:0] gnt_n, done_n, active_n;
    logic            tick_n, busy_n, found, wrap;
    logic [DW-1:0]   dsel;
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    assign dsel = dly[int'(win)*DW +: DW];
    assign wrap = pre == 32'(DIV - 1);
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pre_n    = pre;
        own_n    = own;
        last_n   = last;
        gnt_n    = '0;
        done_n   = '0;
        active_n = active;
        tick_n   = 1'b0;
        case (state)
            IDLE: if (found) begin
                gnt_n    = NREQ'(1) << win;
                active_n = NREQ'(1) << win;
                own_n    = win;
                cnt_n    = dsel;
                pre_n    = '0;
                state_n  = dsel == '0 ? ZERO : RUN;
            end
            RUN: if (cancel) begin
                state_n  = IDLE;
                active_n = '0;
                last_n   = own;
            end else begin
                pre_n = wrap ? '0 : pre + 32'd1;
                if (wrap) begin
                    tick_n = 1'b1;
                    cnt_n  = cnt - DW'(1);
                    if (cnt == DW'(1)) begin
                        state_n = DONE;
                        done_n  = active;
                    end
                end
            end
            ZERO: begin
                state_n = DONE;
                done_n  = active;
            end
            default: begin
                state_n  = IDLE;
                active_n = '0;
                last_n   = own;
            end
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pre    <= '0;
            own    <= '0;
            last   <= IW'(NREQ - 1);
            gnt    <= '0;
            done   <= '0;
            active <= '0;
            busy   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pre    <= pre_n;
            own    <= own_n;
            last   <= last_n;
            gnt    <= gnt_n;
            done   <= done_n;
            active <= active_n;
            busy   <= busy_n;
            tick   <= tick_n;
        end
    end
endmodule

// File: tb/tb_tick_delay_arbiter.sv
// tb_tick_delay_arbiter: directed and random stimulus against a timeline reference model
module tb_tick_delay_arbiter;
    localparam int NREQ = 3;
    localparam int DIV  = 4;
    localparam int DW   = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*DW-1:0] dly = '0;
    logic cancel = 1'b0;
    logic [NREQ-1:0] gnt, done, active;
    logic busy, tick;
    int checks = 0;
    int errors = 0;
    int own = -1, last = NREQ - 1, g = 0, d = 0, fin = 0, n = 0;
    logic [NREQ-1:0] e_gnt = '0, e_done = '0;
    logic e_tick = 1'b0;
    tick_delay_arbiter #(.NREQ(NREQ), .DIV(DIV), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .dly(dly), .cancel(cancel),
        .gnt(gnt), .done(done), .active(active), .busy(busy), .tick(tick)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask
    task automatic model_reset();
        own = -1;
        last = NREQ - 1;
        e_gnt = '0;
        e_done = '0;
        e_tick = 1'b0;
    endtask
    // Timeline model: a grant at edge g with delay d completes at edge fin
    // (g+1 for d=0, else g+d*DIV), ticks every DIV edges, and frees the timer one edge later.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] dl, input logic c);
        n++;
        e_gnt = '0;
        e_done = '0;
        e_tick = 1'b0;
        if (own < 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                int k = (last + i) % NREQ;
                if (own < 0 && r[k]) begin
                    own = k;
                    g = n;
                    d = int'(dl[k*DW +: DW]);
                    fin = d == 0 ? n + 1 : n + d * DIV;
                    e_gnt = NREQ'(1) << k;
                end
            end
        end else if (n == fin + 1) begin
            last = own;
            own = -1;
        end else if (d > 0 && c) begin
            last = own;
            own = -1;
        end else begin
            e_tick = d > 0 && (n - g) % DIV == 0;
            e_done = n == fin ? NREQ'(1) << own : '0;
        end
    endtask
    task automatic compare();
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("active", 32'(active), own < 0 ? 32'd0 : 32'(1) << own);
        chk("busy", 32'(busy), 32'(own >= 0));
    endtask
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] dl, input logic c);
        @(negedge clk);
        req = r;
        dly = dl;
        cancel = c;
        @(posedge clk);
        #1;
        step(r, dl, c);
        compare();
    endtask
    initial begin
        logic [NREQ-1:0] r;
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;
        cyc(3'b001, 24'h000003, 1'b0);
        repeat (16) cyc(3'b000, 24'h0, 1'b0);
        cyc(3'b010, 24'h000000, 1'b0);
        repeat (4) cyc(3'b000, 24'h0, 1'b0);
        repeat (26) cyc(3'b111, 24'h010101, 1'b0);
        repeat (8) cyc(3'b000, 24'h0, 1'b0);
        cyc(3'b001, 24'h000005, 1'b0);
        repeat (6) cyc(3'b010, 24'h000200, 1'b0);
        cyc(3'b010, 24'h000200, 1'b1);
        repeat (14) cyc(3'b000, 24'h0, 1'b0);
        cyc(3'b001, 24'h000001, 1'b0);
        repeat (3) cyc(3'b000, 24'h0, 1'b0);
        cyc(3'b000, 24'h0, 1'b1);
        repeat (3) cyc(3'b000, 24'h0, 1'b0);
        cyc(3'b001, 24'h000004, 1'b0);
        repeat (5) cyc(3'b000, 24'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst = 1'b0;
        cyc(3'b011, 24'h000202, 1'b0);
        repeat (20) cyc(3'b000, 24'h0, 1'b0);
        r = '0;
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 7));
            cyc(r, NREQ*DW'($urandom) & 24'h030303, $urandom_range(0, 19) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
